// File: rtl/nn_div_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : nn_div_sequencer
// Description : Front-end sequencer for the 16-iteration non-restoring
//               divisor. Accepts signed numerator/denominator pairs, runs the
//               divisor START/Finish handshake, applies sign correction to the
//               magnitude quotient and presents the signed result downstream.
//               Optional feature macro: DIV_ZERO_BYPASS_EN (zero-denominator
//               bypass straight to the output with an error flag).
// Revision    : 1.0 - initial release
// ============================================================================
module nn_div_sequencer #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              CLOCK,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_num,
  input  logic [DATA_W-1:0] in_den,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_quot,
  output logic              out_err,
  output logic              busy,
  output logic [DATA_W-1:0] div_top,
  output logic [DATA_W-1:0] div_divisor,
  output logic              div_start,
  output logic              div_reset,
  input  logic              div_finish,
  input  logic [DATA_W-1:0] div_quotient
);

  localparam int TIMER_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_ACK    = 3'd3,
    S_ABORT  = 3'd4,
    S_DRAIN  = 3'd5,
    S_OUT    = 3'd6
  } state_t;

  state_t              state, state_n;
  logic [TIMER_W-1:0]  timer, timer_n;
  logic                sign, sign_n;
  logic [DATA_W-1:0]   q, q_n;
  logic                err, err_n;
  logic [DATA_W-1:0]   top_r, top_n;
  logic [DATA_W-1:0]   dvs_r, dvs_n;
  logic [DATA_W-1:0]   quot_r, quot_n;
  logic                oerr_r, oerr_n;

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge CLOCK) begin
    if (reset) begin
      state  <= S_IDLE;
      timer  <= '0;
      sign   <= 1'b0;
      q      <= '0;
      err    <= 1'b0;
      top_r  <= '0;
      dvs_r  <= '0;
      quot_r <= '0;
      oerr_r <= 1'b0;
    end else begin
      state  <= state_n;
      timer  <= timer_n;
      sign   <= sign_n;
      q      <= q_n;
      err    <= err_n;
      top_r  <= top_n;
      dvs_r  <= dvs_n;
      quot_r <= quot_n;
      oerr_r <= oerr_n;
    end
  end

  // Next-state and next-datapath logic for the handshake sequence.
  always_comb begin
    state_n = state;
    timer_n = timer;
    sign_n  = sign;
    q_n     = q;
    err_n   = err;
    top_n   = top_r;
    dvs_n   = dvs_r;
    quot_n  = quot_r;
    oerr_n  = oerr_r;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          top_n  = in_num;
          dvs_n  = in_den;
          // Divisor treats bit 15 of the denominator as its sign bit.
          sign_n = in_num[DATA_W-1] ^ in_den[15];
          err_n  = 1'b0;
          q_n    = '0;
`ifdef DIV_ZERO_BYPASS_EN
          if (in_den[15:0] == 16'd0) begin
            // Saturate towards the numerator's sign without touching the divisor.
            quot_n  = in_num[DATA_W-1] ? {1'b1, {(DATA_W-2){1'b0}}, 1'b1}
                                       : {1'b0, {(DATA_W-1){1'b1}}};
            oerr_n  = 1'b1;
            state_n = S_OUT;
          end else begin
            state_n = S_LAUNCH;
          end
`else
          state_n = S_LAUNCH;
`endif
        end
      end
      S_LAUNCH: begin
        timer_n = '0;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        // Finish wins over a simultaneous timeout.
        if (div_finish) begin
          q_n     = div_quotient;
          state_n = S_ACK;
        end else if (timer == TIMER_W'(TIMEOUT - 1)) begin
          err_n   = 1'b1;
          q_n     = '0;
          state_n = S_ABORT;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      S_ACK:   state_n = S_DRAIN;
      S_ABORT: state_n = S_DRAIN;
      S_DRAIN: begin
        // Wait for Finish to drop so the next launch cannot see a stale one.
        if (!div_finish) begin
          quot_n  = sign ? (~q + 1'b1) : q;
          oerr_n  = err;
          state_n = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign in_ready    = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign out_valid   = (state == S_OUT);
  assign out_quot    = quot_r;
  assign out_err     = oerr_r;
  assign div_top     = top_r;
  assign div_divisor = dvs_r;
  assign div_start   = (state == S_LAUNCH) || (state == S_ACK);
  assign div_reset   = (state == S_ABORT);

endmodule
`default_nettype wire

// File: tb/tb_nn_div_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_nn_div_sequencer
// Description : Directed self-checking bench for nn_div_sequencer with a
//               behavioural divisor stub (fixed latency, optional no-finish).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nn_div_sequencer;

  localparam int LAT = 18;

  logic        CLOCK = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_num = '0;
  logic [31:0] in_den = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_quot;
  logic        out_err;
  logic        busy;
  logic [31:0] div_top;
  logic [31:0] div_divisor;
  logic        div_start;
  logic        div_reset;
  logic        div_finish = 1'b0;
  logic [31:0] div_quotient = '0;

  int tests = 0;
  int fails = 0;

  nn_div_sequencer #(.DATA_W(32), .TIMEOUT(64)) dut (
    .CLOCK(CLOCK), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_num(in_num), .in_den(in_den),
    .out_valid(out_valid), .out_ready(out_ready), .out_quot(out_quot), .out_err(out_err),
    .busy(busy), .div_top(div_top), .div_divisor(div_divisor),
    .div_start(div_start), .div_reset(div_reset),
    .div_finish(div_finish), .div_quotient(div_quotient)
  );

  always #5 CLOCK = ~CLOCK;

  // Divisor stub: magnitude-only result after LAT cycles, Finish held until START.
  bit          never_finish = 1'b0;
  bit          sbusy = 1'b0;
  int          scnt = 0;
  logic [31:0] sres = '0;

  function automatic logic [31:0] mag_div(input logic [31:0] t, input logic [31:0] d);
    logic [31:0] an;
    logic [15:0] ad;
    an = t[31] ? (~t + 32'd1) : t;
    ad = d[15] ? (~d[15:0] + 16'd1) : d[15:0];
    if (ad == 16'd0) return 32'hFFFF_FFFF;
    return an / {16'd0, ad};
  endfunction

  always @(posedge CLOCK) begin
    if (reset || div_reset) begin
      sbusy      <= 1'b0;
      div_finish <= 1'b0;
      scnt       <= 0;
    end else if (sbusy) begin
      if (!never_finish) begin
        if (scnt == LAT - 1) begin
          div_finish   <= 1'b1;
          div_quotient <= sres;
          sbusy        <= 1'b0;
        end else begin
          scnt <= scnt + 1;
        end
      end
    end else if (div_finish) begin
      if (div_start) div_finish <= 1'b0;
    end else if (div_start) begin
      sbusy <= 1'b1;
      scnt  <= 0;
      sres  <= mag_div(div_top, div_divisor);
    end
  end

  // Pulse monitor
  int cyc = 0;
  int start_cnt = 0;
  int reset_cnt = 0;
  int first_start = -1;
  int reset_at = -1;
  always @(posedge CLOCK) begin
    cyc = cyc + 1;
    if (div_start) begin
      start_cnt = start_cnt + 1;
      if (first_start < 0) first_start = cyc;
    end
    if (div_reset) begin
      reset_cnt = reset_cnt + 1;
      reset_at  = cyc;
    end
  end

  task automatic clear_mon();
    start_cnt = 0; reset_cnt = 0; first_start = -1; reset_at = -1;
  endtask

  // One full operation with out_ready high; returns at a negedge in IDLE.
  task automatic do_op(input logic [31:0] num, input logic [31:0] den,
                       output logic [31:0] q, output logic e, output int lat, output bit to);
    @(negedge CLOCK);
    in_num = num; in_den = den; in_valid = 1'b1;
    @(posedge CLOCK);
    @(negedge CLOCK);
    in_valid = 1'b0;
    lat = 1; to = 1'b0;
    while (!out_valid && lat < 100) begin
      @(negedge CLOCK);
      lat++;
    end
    if (!out_valid) to = 1'b1;
    q = out_quot; e = out_err;
    @(negedge CLOCK);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge CLOCK);
    @(negedge CLOCK);
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags: in_ready=%b out_valid=%b busy=%b out_err=%b, want 1 0 0 0",
               in_ready, out_valid, busy, out_err);
    end
    tests++;
    if (out_quot !== 32'd0 || div_top !== 32'd0 || div_divisor !== 32'd0) begin
      fails++;
      $display("FAIL reset_data: out_quot=%h div_top=%h div_divisor=%h, want 0", out_quot, div_top, div_divisor);
    end
    tests++;
    if (div_start !== 1'b0 || div_reset !== 1'b0) begin
      fails++;
      $display("FAIL reset_div: div_start=%b div_reset=%b, want 0 0", div_start, div_reset);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] q; logic e; int lat; bit to;
    clear_mon();
    do_op(32'd100, 32'd7, q, e, lat, to);
    tests++;
    if (to || q !== 32'd14 || e !== 1'b0) begin
      fails++;
      $display("FAIL basic_100_7: quot=%h err=%b timeout=%b, want 0000000e 0 0", q, e, to);
    end
    tests++;
    if (lat > 26) begin
      fails++;
      $display("FAIL basic_latency: %0d cycles, want <= 26", lat);
    end
    tests++;
    if (start_cnt !== 2 || reset_cnt !== 0) begin
      fails++;
      $display("FAIL basic_pulses: starts=%0d resets=%0d, want 2 0", start_cnt, reset_cnt);
    end
  endtask

  task automatic test_signs();
    logic [31:0] nums [3] = '{32'hFFFF_FF9C, 32'd100,      32'hFFFF_FF9C};
    logic [31:0] dens [3] = '{32'd7,        32'hFFFF_FFF9, 32'hFFFF_FFF9};
    logic [31:0] exps [3] = '{32'hFFFF_FFF2, 32'hFFFF_FFF2, 32'd14};
    logic [31:0] q; logic e; int lat; bit to;
    for (int i = 0; i < 3; i++) begin
      do_op(nums[i], dens[i], q, e, lat, to);
      tests++;
      if (to || q !== exps[i] || e !== 1'b0) begin
        fails++;
        $display("FAIL sign_%0d: quot=%h err=%b timeout=%b, want %h 0 0", i, q, e, to, exps[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    clear_mon();
    out_ready = 1'b0;
    @(negedge CLOCK);
    in_num = 32'd100; in_den = 32'd7; in_valid = 1'b1;
    @(posedge CLOCK);
    @(negedge CLOCK);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge CLOCK);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      in_num = 32'd200; in_den = 32'd7; in_valid = 1'b1;
      tests++;
      if (out_valid !== 1'b1 || out_quot !== 32'd14 || out_err !== 1'b0 || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL hold_%0d: valid=%b quot=%h err=%b in_ready=%b, want 1 0000000e 0 0",
                 i, out_valid, out_quot, out_err, in_ready);
      end
      @(negedge CLOCK);
    end
    tests++;
    if (start_cnt !== 2) begin
      fails++;
      $display("FAIL hold_no_accept: starts=%0d, want 2", start_cnt);
    end
    out_ready = 1'b1;
    @(negedge CLOCK);
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL release_idle: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    @(negedge CLOCK);
    in_valid = 1'b0;
    tests++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL release_accept: busy=%b in_ready=%b, want 1 0", busy, in_ready);
    end
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge CLOCK);
      n++;
    end
    tests++;
    if (out_valid !== 1'b1 || out_quot !== 32'd28) begin
      fails++;
      $display("FAIL release_result: valid=%b quot=%h, want 1 0000001c", out_valid, out_quot);
    end
    @(negedge CLOCK);
  endtask

  task automatic test_timeout();
    logic [31:0] q; logic e; int lat; bit to;
    clear_mon();
    never_finish = 1'b1;
    do_op(32'd100, 32'd7, q, e, lat, to);
    never_finish = 1'b0;
    tests++;
    if (to || q !== 32'd0 || e !== 1'b1) begin
      fails++;
      $display("FAIL timeout_result: quot=%h err=%b timeout=%b, want 0 1 0", q, e, to);
    end
    tests++;
    if (reset_cnt !== 1 || start_cnt !== 1 || (reset_at - first_start) !== 65) begin
      fails++;
      $display("FAIL timeout_pulses: resets=%0d starts=%0d gap=%0d, want 1 1 65",
               reset_cnt, start_cnt, reset_at - first_start);
    end
    tests++;
    if (lat !== 68) begin
      fails++;
      $display("FAIL timeout_latency: %0d cycles, want 68", lat);
    end
    tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL timeout_idle: in_ready=%b busy=%b, want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_zero_den();
    logic [31:0] q; logic e; int lat; bit to;
    clear_mon();
    do_op(32'd5, 32'd0, q, e, lat, to);
`ifdef DIV_ZERO_BYPASS_EN
    tests++;
    if (to || q !== 32'h7FFF_FFFF || e !== 1'b1 || lat !== 1) begin
      fails++;
      $display("FAIL zero_bypass: quot=%h err=%b lat=%0d, want 7fffffff 1 1", q, e, lat);
    end
    tests++;
    if (start_cnt !== 0) begin
      fails++;
      $display("FAIL zero_no_start: starts=%0d, want 0", start_cnt);
    end
`else
    tests++;
    if (to || q !== 32'hFFFF_FFFF || e !== 1'b0) begin
      fails++;
      $display("FAIL zero_raw: quot=%h err=%b timeout=%b, want ffffffff 0 0", q, e, to);
    end
    tests++;
    if (start_cnt !== 2) begin
      fails++;
      $display("FAIL zero_starts: starts=%0d, want 2", start_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic [31:0] q; logic e; int lat; bit to;
    @(negedge CLOCK);
    in_num = 32'd100; in_den = 32'd7; in_valid = 1'b1;
    @(posedge CLOCK);
    @(negedge CLOCK);
    in_valid = 1'b0;
    repeat (6) @(negedge CLOCK);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL mid_busy: busy=%b, want 1", busy);
    end
    reset = 1'b1;
    @(negedge CLOCK);
    reset = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || div_start !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: in_ready=%b out_valid=%b div_start=%b busy=%b, want 1 0 0 0",
               in_ready, out_valid, div_start, busy);
    end
    do_op(32'd100, 32'd7, q, e, lat, to);
    tests++;
    if (to || q !== 32'd14 || e !== 1'b0) begin
      fails++;
      $display("FAIL mid_recover: quot=%h err=%b timeout=%b, want 0000000e 0 0", q, e, to);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_backpressure();
    test_timeout();
    test_zero_den();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
